// File: rtl/user_input_debounce.sv
// Button/switch conditioner: polarity normalise, 2-FF synchroniser, then a
// consecutive-sample debounce FSM driving registered 'out' and 'pending'.
module user_input_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic pending
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               SINGLE = (DEBOUNCE_CYCLES == 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             n, s1, s2;
  logic             out_d, pending_d;

  assign n = ACTIVE_LOW ? ~in : in;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      out     <= 1'b0;
      pending <= 1'b0;
    end else begin
      s1      <= n;
      s2      <= s1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out     <= out_d;
      pending <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LO: if (s2) begin
        if (SINGLE) state_d = IDLE_HI;
        else begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: if (s2) begin
        if (cnt_q == LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
      IDLE_HI: if (!s2) begin
        if (SINGLE) state_d = IDLE_LO;
        else begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: if (!s2) begin
        if (cnt_q == LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = IDLE_HI;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    out_d     = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    pending_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

endmodule

// File: tb/tb_user_input_debounce.sv
// Scoreboard bench: stimulus queues per-cycle expected out/pending; a monitor
// pops and compares one entry after every rising edge.
module tb_user_input_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in0 = 1'b0, in1 = 1'b0, in2 = 1'b1;
  logic o0, o1, o2, p0, p1, p2;

  always #5 clk = ~clk;

  user_input_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b0)) dut_n4 (
    .clk(clk), .rst(rst), .in(in0), .out(o0), .pending(p0));
  user_input_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(1), .ACTIVE_LOW(1'b0)) dut_n1 (
    .clk(clk), .rst(rst), .in(in1), .out(o1), .pending(p1));
  user_input_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .in(in2), .out(o2), .pending(p2));

  typedef struct {
    int unsigned sel;
    logic        eo;
    logic        ep;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: one expected entry per clock, checked 1 time unit after posedge.
  initial begin
    exp_t e;
    logic ao, ap;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0: begin ao = o0; ap = p0; end
          1: begin ao = o1; ap = p1; end
          default: begin ao = o2; ap = p2; end
        endcase
        tests++;
        if (ao !== e.eo) begin
          fails++;
          $display("FAIL %s dut%0d out: got %b expected %b", e.tag, e.sel, ao, e.eo);
        end
        tests++;
        if (ap !== e.ep) begin
          fails++;
          $display("FAIL %s dut%0d pending: got %b expected %b", e.tag, e.sel, ap, e.ep);
        end
      end
    end
  end

  task automatic cyc(input int unsigned sel, input logic r, input logic v,
                     input logic eo, input logic ep, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    case (sel)
      0: in0 = v;
      1: in1 = v;
      default: in2 = v;
    endcase
    e.sel = sel; e.eo = eo; e.ep = ep; e.tag = tag;
    q.push_back(e);
  endtask

  // Full qualification of a level change on dut sel; idle level 'from'.
  task automatic qualify(input int unsigned sel, input logic v, input logic from_out,
                         input string tag);
    cyc(sel, 1'b0, v, from_out, 1'b0, tag);
    cyc(sel, 1'b0, v, from_out, 1'b0, tag);
    repeat (3) cyc(sel, 1'b0, v, from_out, 1'b1, tag);
    cyc(sel, 1'b0, v, ~from_out, 1'b0, tag);
  endtask

  initial begin
    // 1: reset held, then released with idle inputs
    repeat (3) cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hold");
    cyc(1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hold_n1");
    cyc(2, 1'b1, 1'b1, 1'b0, 1'b0, "rst_hold_al");
    repeat (3) cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_release");

    // 2: clean rise and clean fall
    qualify(0, 1'b1, 1'b0, "rise");
    repeat (2) cyc(0, 1'b0, 1'b1, 1'b1, 1'b0, "hold_hi");
    qualify(0, 1'b0, 1'b1, "fall");
    repeat (2) cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, "hold_lo");

    // 3: two-cycle bounce aborts; then single-cycle toggling
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, "bounce");
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, "bounce");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, "bounce");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b1, "bounce");
    cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_abort");
    repeat (2) cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, "bounce_idle");
    for (int i = 1; i <= 12; i++) begin
      logic v, ep;
      v  = (i <= 10) && (i % 2 == 1);
      ep = (i >= 3) && (i <= 11) && (i % 2 == 1);
      cyc(0, 1'b0, v, 1'b0, ep, "toggle");
    end

    // 4: reset mid-WAIT_HI forces full re-qualification
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, "mid_rst");
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, "mid_rst");
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, "mid_rst_wait");
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, "mid_rst_hit");
    qualify(0, 1'b1, 1'b0, "after_rst");
    qualify(0, 1'b0, 1'b1, "after_rst_fall");

    // 5: N=1 passes a one-cycle pulse
    cyc(1, 1'b0, 1'b1, 1'b0, 1'b0, "n1_pulse");
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, "n1_pulse");
    cyc(1, 1'b0, 1'b0, 1'b1, 1'b0, "n1_out_hi");
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, "n1_out_lo");
    cyc(1, 1'b0, 1'b0, 1'b0, 1'b0, "n1_idle");

    // 6: active-low input
    repeat (2) cyc(2, 1'b0, 1'b1, 1'b0, 1'b0, "al_idle");
    qualify(2, 1'b0, 1'b0, "al_press");
    cyc(2, 1'b0, 1'b0, 1'b1, 1'b0, "al_hold");
    qualify(2, 1'b1, 1'b1, "al_release");

    begin
      int unsigned guard = 0;
      while (q.size() > 0 && guard < 10) begin
        @(posedge clk);
        #2;
        guard++;
      end
      if (q.size() > 0) begin
        fails++;
        $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
